// File: rtl/icache_pkg.sv
// Shared fetch-side definitions: bus widths and the instruction cache state encodings.
package icache_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid/tag/data per line.
// One synchronous write port and one combinational read port.
// Only the valid bits are reset; tag and data are qualified by valid.
module icache_array
  import icache_pkg::*;
#(
  parameter int ENTRIES = 256,
  parameter int IDX_W   = 8,
  parameter int TAG_W   = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [INST_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [INST_W-1:0] rd_data
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [INST_W-1:0]  data_q [ENTRIES];

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data payload, written on fill.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  // Combinational lookup for the current fetch index.
  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_tag   = tag_q[rd_idx];
    rd_data  = data_q[rd_idx];
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between fetch and the memory controller.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IC_IDLE | ready for a fetch request; hits answered on the next edge
//   IC_MISS | fill request outstanding, waiting for MC_IC_valid
//
// The drop flag remembers a redirect seen while a fill was outstanding so
// the fill still lands in the array but no response reaches fetch.
module icache
  import icache_pkg::*;
#(
  parameter int ENTRIES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              IF_IC_valid,
  input  logic [ADDR_W-1:0] IF_IC_pc,
  output logic              IC_ready,
  output logic              IC_Instr_valid,
  output logic [INST_W-1:0] IC_Instr,
  input  logic              clear,
  output logic              IC_MC_req,
  output logic [ADDR_W-1:0] IC_MC_addr,
  input  logic              MC_IC_valid,
  input  logic [INST_W-1:0] MC_IC_data
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  ic_state_e         state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:2] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [INST_W-1:0] instr_q, instr_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              arr_we;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [INST_W-1:0] rd_data;
  logic              hit;

  // Byte offset within a word plays no part in an instruction fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = ^IF_IC_pc[1:0];

  icache_array #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (arr_we && rdy),
    .wr_idx  (pc_q[IDX_W+1:2]),
    .wr_tag  (pc_q[ADDR_W-1:IDX_W+2]),
    .wr_data (MC_IC_data),
    .rd_idx  (IF_IC_pc[IDX_W+1:2]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data)
  );

  assign hit = rd_valid && (rd_tag == IF_IC_pc[ADDR_W-1:IDX_W+2]);

  // Next-state and next-output decode; the response pulse defaults low.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    pc_d    = pc_q;
    valid_d = 1'b0;
    instr_d = instr_q;
    req_d   = req_q;
    addr_d  = addr_q;
    arr_we  = 1'b0;
    case (state_q)
      IC_IDLE: begin
        drop_d = 1'b0;
        if (IF_IC_valid && !clear) begin
          if (hit) begin
            valid_d = 1'b1;
            instr_d = rd_data;
          end else begin
            pc_d    = IF_IC_pc[ADDR_W-1:2];
            req_d   = 1'b1;
            addr_d  = {IF_IC_pc[ADDR_W-1:2], 2'b00};
            state_d = IC_MISS;
          end
        end
      end
      IC_MISS: begin
        if (clear) drop_d = 1'b1;
        if (MC_IC_valid) begin
          arr_we  = 1'b1;
          req_d   = 1'b0;
          drop_d  = 1'b0;
          state_d = IC_IDLE;
          valid_d = !(drop_q || clear);
          instr_d = MC_IC_data;
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  // State and output registers; rdy low freezes everything except reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IC_IDLE;
      drop_q  <= 1'b0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign IC_ready       = (state_q == IC_IDLE);
  assign IC_Instr_valid = valid_q;
  assign IC_Instr       = instr_q;
  assign IC_MC_req      = req_q;
  assign IC_MC_addr     = addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by randomized
// fetches, all checked against a line-level model of the cache contents.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        IF_IC_valid;
  logic [31:0] IF_IC_pc;
  logic        IC_ready;
  logic        IC_Instr_valid;
  logic [31:0] IC_Instr;
  logic        clear;
  logic        IC_MC_req;
  logic [31:0] IC_MC_addr;
  logic        MC_IC_valid;
  logic [31:0] MC_IC_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: 256 lines, index pc[9:2], tag pc[31:10].
  bit          m_valid [256];
  logic [21:0] m_tag   [256];
  logic [31:0] m_data  [256];

  icache dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .IF_IC_valid   (IF_IC_valid),
    .IF_IC_pc      (IF_IC_pc),
    .IC_ready      (IC_ready),
    .IC_Instr_valid(IC_Instr_valid),
    .IC_Instr      (IC_Instr),
    .clear         (clear),
    .IC_MC_req     (IC_MC_req),
    .IC_MC_addr    (IC_MC_addr),
    .MC_IC_valid   (MC_IC_valid),
    .MC_IC_data    (MC_IC_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[pc[9:2]] && (m_tag[pc[9:2]] == pc[31:10]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  // One complete fetch transaction. On a miss: wait `delay` cycles, optionally
  // pulse clear (first wait cycle, or together with the fill when delay is 0),
  // optionally stall with rdy low, optionally issue an ignored request while busy.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] fill, input bit clr,
                       input int stall, input int delay, input bit busy_req);
    bit hit;
    hit = model_hit(pc);
    chk("ready_before_req", IC_ready, 1);
    IF_IC_valid = 1'b1;
    IF_IC_pc    = pc;
    tick();
    IF_IC_valid = 1'b0;
    if (hit) begin
      chk("hit_valid", IC_Instr_valid, 1);
      chk("hit_data", IC_Instr, m_data[pc[9:2]]);
      chk("hit_no_req", IC_MC_req, 0);
      chk("hit_ready", IC_ready, 1);
    end else begin
      chk("miss_req", IC_MC_req, 1);
      chk("miss_addr", IC_MC_addr, {pc[31:2], 2'b00});
      chk("miss_not_ready", IC_ready, 0);
      chk("miss_no_valid", IC_Instr_valid, 0);
      for (int i = 0; i < delay; i++) begin
        if (clr && i == 0) clear = 1'b1;
        if (busy_req && i == 0) begin
          IF_IC_valid = 1'b1;
          IF_IC_pc    = 32'h20;
        end
        tick();
        clear       = 1'b0;
        IF_IC_valid = 1'b0;
        chk("wait_req", IC_MC_req, 1);
        chk("wait_addr", IC_MC_addr, {pc[31:2], 2'b00});
        chk("wait_not_ready", IC_ready, 0);
        chk("wait_no_valid", IC_Instr_valid, 0);
      end
      if (stall > 0) begin
        rdy = 1'b0;
        for (int i = 0; i < stall; i++) begin
          tick();
          chk("stall_req", IC_MC_req, 1);
          chk("stall_addr", IC_MC_addr, {pc[31:2], 2'b00});
          chk("stall_not_ready", IC_ready, 0);
          chk("stall_no_valid", IC_Instr_valid, 0);
        end
        rdy = 1'b1;
      end
      MC_IC_valid = 1'b1;
      MC_IC_data  = fill;
      if (clr && delay == 0) clear = 1'b1;
      tick();
      MC_IC_valid = 1'b0;
      clear       = 1'b0;
      chk("fill_valid", IC_Instr_valid, {31'b0, !clr});
      if (!clr) chk("fill_data", IC_Instr, fill);
      chk("fill_req_drop", IC_MC_req, 0);
      chk("fill_ready", IC_ready, 1);
      m_valid[pc[9:2]] = 1'b1;
      m_tag[pc[9:2]]   = pc[31:10];
      m_data[pc[9:2]]  = fill;
    end
    tick();
    chk("single_pulse", IC_Instr_valid, 0);
  endtask

  // Request and redirect in the same IDLE cycle: dropped, no fill, no response.
  task automatic req_with_clear(input logic [31:0] pc);
    IF_IC_valid = 1'b1;
    IF_IC_pc    = pc;
    clear       = 1'b1;
    tick();
    IF_IC_valid = 1'b0;
    clear       = 1'b0;
    chk("clr_req_no_valid", IC_Instr_valid, 0);
    chk("clr_req_no_req", IC_MC_req, 0);
    chk("clr_req_ready", IC_ready, 1);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] pa, pb;
    model_clear();
    rst = 1'b1; rdy = 1'b1; IF_IC_valid = 1'b0; IF_IC_pc = '0;
    clear = 1'b0; MC_IC_valid = 1'b0; MC_IC_data = '0;
    tick();
    tick();
    chk("rst_valid", IC_Instr_valid, 0);
    chk("rst_instr", IC_Instr, 0);
    chk("rst_req", IC_MC_req, 0);
    chk("rst_addr", IC_MC_addr, 0);
    chk("rst_ready", IC_ready, 1);
    rst = 1'b0;
    tick();

    // Cold miss then hit.
    fetch(32'h0, 32'h00000013, 0, 0, 1, 0);
    fetch(32'h0, 32'hdeadbeef, 0, 0, 0, 0);
    // Conflict eviction.
    fetch(32'h400, 32'h00100093, 0, 0, 2, 0);
    fetch(32'h0, 32'h00000013, 0, 0, 0, 0);
    // Clear during miss, then hit on the silently filled line.
    fetch(32'h8, 32'h00a00113, 1, 0, 2, 0);
    fetch(32'h8, 32'h0, 0, 0, 0, 0);
    // Clear coincident with fill.
    fetch(32'hc, 32'h12345678, 1, 0, 0, 0);
    fetch(32'hc, 32'h0, 0, 0, 0, 0);
    // rdy stall during miss.
    fetch(32'h10, 32'h00208233, 0, 3, 1, 0);
    // Busy: request 0x20 during MISS is ignored; 0x20 still misses later.
    fetch(32'h14, 32'h0badf00d, 0, 0, 2, 1);
    fetch(32'h20, 32'h00c00193, 0, 0, 1, 0);
    // Request with clear on a line that would hit.
    req_with_clear(32'h8);

    // Back-to-back hits: one response per cycle.
    pa = 32'h8; pb = 32'h10;
    for (int i = 0; i < 4; i++) begin
      pc = (i % 2 == 0) ? pa : pb;
      IF_IC_valid = 1'b1;
      IF_IC_pc    = pc;
      tick();
      chk("b2b_valid", IC_Instr_valid, 1);
      chk("b2b_data", IC_Instr, m_data[pc[9:2]]);
    end
    IF_IC_valid = 1'b0;
    tick();
    chk("b2b_end", IC_Instr_valid, 0);

    // Reset in the middle of a miss.
    IF_IC_valid = 1'b1;
    IF_IC_pc    = 32'h30;
    tick();
    IF_IC_valid = 1'b0;
    chk("rm_req", IC_MC_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    chk("rm_req_low", IC_MC_req, 0);
    chk("rm_ready", IC_ready, 1);
    chk("rm_addr", IC_MC_addr, 0);
    MC_IC_valid = 1'b1;
    MC_IC_data  = 32'hffffffff;
    tick();
    MC_IC_valid = 1'b0;
    chk("stale_no_valid", IC_Instr_valid, 0);
    chk("stale_ready", IC_ready, 1);
    chk("stale_no_req", IC_MC_req, 0);
    fetch(32'h8, 32'h00a00113, 0, 0, 1, 0);
    fetch(32'h30, 32'h55aa55aa, 0, 0, 0, 0);

    // Randomized traffic over a small set of indices and tags to force conflicts.
    for (int it = 0; it < 300; it++) begin
      pc = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) begin
        req_with_clear(pc);
      end else begin
        fetch(pc, $urandom, ($urandom_range(0, 4) == 0), $urandom_range(0, 2),
              $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
